// File: rtl/seq_bit_serializer.sv
// rtl/seq_bit_serializer.sv - WIDTH-bit word to MSB-first serial bit stream, valid/ready input.
// Optional build macro SER_PARITY_EN appends one even-parity bit per frame.
module seq_bit_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_done
);

`ifdef SER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(FLEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SER_PARITY_EN
    , PAR
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-2:0] sreg_q, sreg_d;
  logic             bo_q, bo_d;
  logic             bv_q, bv_d;
  logic             fd_q, fd_d;
  logic             last_bit;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  // cnt_q holds the number of frame bits left, including the one now on bit_out
  assign last_bit   = (state_q != IDLE) && (cnt_q == CW'(1));
  assign s_ready    = rst_n && ((state_q == IDLE) || last_bit);
  assign accept     = s_valid && s_ready;
  assign bit_out    = bo_q;
  assign bit_valid  = bv_q;
  assign busy       = bv_q;
  assign frame_done = fd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    bo_d    = bo_q;
    bv_d    = bv_q;
    fd_d    = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    if ((state_q == IDLE) || last_bit) begin
      if (accept) begin
        state_d = SHIFT;
        cnt_d   = CW'(FLEN);
        sreg_d  = s_data[WIDTH-2:0];
        bo_d    = s_data[WIDTH-1];
        bv_d    = 1'b1;
`ifdef SER_PARITY_EN
        par_d   = ^s_data;
`endif
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        bo_d    = IDLE_BIT;
        bv_d    = 1'b0;
      end
    end else begin
      cnt_d  = cnt_q - CW'(1);
      sreg_d = sreg_q << 1;
      bv_d   = 1'b1;
      fd_d   = (cnt_q == CW'(2));
`ifdef SER_PARITY_EN
      // data bit 0 is on the line: parity goes out next
      if (cnt_q == CW'(2)) begin
        state_d = PAR;
        bo_d    = par_q;
      end else begin
        bo_d    = sreg_q[WIDTH-2];
      end
`else
      bo_d = sreg_q[WIDTH-2];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      bo_q    <= IDLE_BIT;
      bv_q    <= 1'b0;
      fd_q    <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      bo_q    <= bo_d;
      bv_q    <= bv_d;
      fd_q    <= fd_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb/tb_seq_bit_serializer.sv - directed self-checking bench for seq_bit_serializer.
module tb_seq_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, bit_out, bit_valid, busy, frame_done;
  logic       i1_ready, i1_bit_out, i1_bit_valid, i1_busy, i1_frame_done;

  int n_cmp = 0;
  int n_err = 0;
  logic obs [0:15];

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .busy(busy), .frame_done(frame_done)
  );

  seq_bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b1)) u_idle1 (
    .clk(clk), .rst_n(rst_n), .s_valid(1'b0), .s_data(8'h00),
    .s_ready(i1_ready), .bit_out(i1_bit_out), .bit_valid(i1_bit_valid),
    .busy(i1_busy), .frame_done(i1_frame_done)
  );

  function automatic logic exp_bit(input logic [7:0] w, input int i);
    if (i < 8) return w[7-i];
    return ^w;
  endfunction

  // Entered #1 after the edge that put the frame's first bit out; leaves #1 after the edge following the last bit.
  task automatic check_frame(input string name, input logic [7:0] w, input logic nv, input logic [7:0] nd);
    logic [4:0] got, exp;
    s_valid = nv;
    s_data  = nd;
    #1;
    for (int i = 0; i < FLEN; i++) begin
      got = {bit_valid, bit_out, frame_done, s_ready, busy};
      exp = {1'b1, exp_bit(w, i), (i == FLEN-1), (i == FLEN-1), 1'b1};
      if (i < 16) obs[i] = bit_out;
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s bit%0d {bv,bo,fd,rdy,busy} got %b want %b", name, i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle(input string name);
    logic [4:0] got;
    got = {bit_valid, bit_out, frame_done, s_ready, busy};
    n_cmp++;
    if (got !== 5'b00010) begin
      n_err++;
      $display("FAIL %s idle {bv,bo,fd,rdy,busy} got %b want 00010", name, got);
    end
  endtask

  task automatic send(input logic [7:0] w);
    s_valid = 1'b1;
    s_data  = w;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [4:0] got;
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    got = {bit_valid, bit_out, frame_done, s_ready, busy};
    n_cmp++;
    if (got !== 5'b00000) begin
      n_err++;
      $display("FAIL reset {bv,bo,fd,rdy,busy} got %b want 00000", got);
    end
    s_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_idle("after_reset");
  endtask

  task automatic test_idle_bit;
    logic [3:0] got;
    for (int c = 0; c < 20; c++) begin
      got = {i1_bit_out, i1_bit_valid, i1_ready, i1_frame_done};
      n_cmp++;
      if (got !== 4'b1010) begin
        n_err++;
        $display("FAIL idle_bit1 cycle%0d {bo,bv,rdy,fd} got %b want 1010", c, got);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_word;
    logic [7:0] y_mask;
    send(8'hD6);
    check_frame("single_D6", 8'hD6, 1'b0, 8'h00);
    check_idle("single_D6_end");
    y_mask = '0;
    for (int k = 2; k < 8; k++)
      if (obs[k-2] && obs[k-1] && !obs[k]) y_mask[k] = 1'b1;
    n_cmp++;
    if (y_mask !== 8'b1000_0100) begin
      n_err++;
      $display("FAIL det110 y positions got %b want 10000100", y_mask);
    end
  endtask

  task automatic test_back_to_back;
    send(8'hC0);
    check_frame("b2b_C0", 8'hC0, 1'b1, 8'h03);
    check_frame("b2b_03", 8'h03, 1'b0, 8'h00);
    check_idle("b2b_end");
  endtask

  task automatic test_backpressure;
    send(8'h3C);
    check_frame("bp_3C", 8'h3C, 1'b1, 8'hFF);
    check_frame("bp_FF", 8'hFF, 1'b0, 8'h00);
    check_idle("bp_end0");
    @(posedge clk); #1;
    check_idle("bp_end1");
  endtask

  task automatic test_mid_reset;
    logic [3:0] got;
    send(8'hAA);
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = {bit_valid, bit_out, frame_done, s_ready};
      n_cmp++;
      if (got !== {1'b1, exp_bit(8'hAA, i), 2'b00}) begin
        n_err++;
        $display("FAIL midrst_AA bit%0d {bv,bo,fd,rdy} got %b want %b", i, got, {1'b1, exp_bit(8'hAA, i), 2'b00});
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    rst_n = 1'b0;
    s_valid = 1'b1; s_data = 8'h55;
    #1;
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst s_ready_in_reset got %b want 0", s_ready);
    end
    @(posedge clk); #1;
    got = {bit_valid, bit_out, frame_done, busy};
    n_cmp++;
    if (got !== 4'b0000) begin
      n_err++;
      $display("FAIL midrst after {bv,bo,fd,busy} got %b want 0000", got);
    end
    s_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_idle("midrst_release");
    send(8'h81);
    check_frame("midrst_81", 8'h81, 1'b0, 8'h00);
    check_idle("midrst_end");
  endtask

  initial begin
    test_reset();
    test_idle_bit();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
